// File: rtl/dac_sample_pacer.sv
// Paced DAC output driver: qualifies PLL lock, buffers a stream of samples in
// a small FIFO and emits one word every max(div,1)+1 clocks with a latch clock.
module dac_sample_pacer #(
  parameter int DATA_W      = 10,
  parameter int DIV_W       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int LOCK_FILTER = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic [DIV_W-1:0]  div,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              clr_underrun,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_clk,
  output logic              running,
  output logic              underrun,
  output logic              underrun_flag
);

  localparam int LCW = $clog2(LOCK_FILTER + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [LCW-1:0]    LOCK_MAX = LCW'(LOCK_FILTER);
  localparam logic [CW-1:0]     FULL     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

  // A divider of zero would give a one-cycle period with no room for dac_clk.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic              running_q, running_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [DIV_W-1:0]  pace_q, pace_d, divm_q, divm_d;
  logic [DATA_W-1:0] dac_data_q, dac_data_d;
  logic              dac_clk_q, dac_clk_d;
  logic              underrun_q, underrun_d;
  logic              flag_q, flag_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              push, pop, strobe;

  assign push   = s_valid && s_ready;
  assign strobe = (state_q == RUN) && (pace_q == '0);
  assign pop    = strobe && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lock_cnt_q <= '0;
      running_q  <= 1'b0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      pace_q     <= '0;
      divm_q     <= DIV_W'(1);
      dac_data_q <= MIDSCALE;
      dac_clk_q  <= 1'b0;
      underrun_q <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= pll_lock;
      sync2_q    <= sync1_q;
      lock_cnt_q <= lock_cnt_d;
      running_q  <= running_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      pace_q     <= pace_d;
      divm_q     <= divm_d;
      dac_data_q <= dac_data_d;
      dac_clk_q  <= dac_clk_d;
      underrun_q <= underrun_d;
      flag_q     <= flag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s_data;
  end

  // Lock filter: running follows one edge after the counter saturates.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!sync2_q)                   lock_cnt_d = '0;
    else if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
    running_d = sync2_q && (lock_cnt_q == LOCK_MAX);
  end

  always_comb begin
    state_d = state_q;
    if (!sync2_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (running_d) state_d = PRIME;
        PRIME:   if (cnt_d == FULL) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered count only, so a full FIFO never accepts even while popping.
  always_comb begin
    s_ready = (state_q != IDLE) && (cnt_q < FULL);
  end

  always_comb begin
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    pace_d     = pace_q;
    divm_d     = divm_q;
    dac_data_d = dac_data_q;
    dac_clk_d  = dac_clk_q;
    underrun_d = 1'b0;
    flag_d     = flag_q && !clr_underrun;
    if (!sync2_q) begin
      cnt_d      = '0;
      wr_d       = '0;
      rd_d       = '0;
      pace_d     = '0;
      dac_data_d = MIDSCALE;
      dac_clk_d  = 1'b0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      case (state_q)
        IDLE: begin
          dac_data_d = MIDSCALE;
          dac_clk_d  = 1'b0;
        end
        PRIME: begin
          dac_clk_d = 1'b0;
          if (cnt_d == FULL) begin
            divm_d = clamp_div(div);
            pace_d = divm_d;
          end
        end
        RUN: begin
          if (strobe) begin
            divm_d = clamp_div(div);
            pace_d = divm_d;
            if (pop) begin
              dac_data_d = mem_q[rd_q];
            end else begin
              underrun_d = 1'b1;
              flag_d     = 1'b1;
            end
          end else begin
            pace_d = pace_q - 1'b1;
          end
          // Low from the strobe, high for the second half of the period.
          dac_clk_d = (pace_d <= (divm_d >> 1));
        end
        default: begin
          dac_clk_d = 1'b0;
        end
      endcase
    end
  end

  assign dac_data      = dac_data_q;
  assign dac_clk       = dac_clk_q;
  assign running       = running_q;
  assign underrun      = underrun_q;
  assign underrun_flag = flag_q;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Bench for dac_sample_pacer: directed lock/underrun/reset sequences plus a
// scoreboard that tracks every accepted sample through to the DAC bus.
module tb_dac_sample_pacer;

  logic        clk;
  logic        rst_n;
  logic        pll_lock;
  logic [15:0] div;
  logic [9:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        clr_underrun;
  logic [9:0]  dac_data;
  logic        dac_clk;
  logic        running;
  logic        underrun;
  logic        underrun_flag;

  dac_sample_pacer #(
    .DATA_W(10), .DIV_W(16), .FIFO_DEPTH(4), .LOCK_FILTER(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .div(div),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .clr_underrun(clr_underrun), .dac_data(dac_data), .dac_clk(dac_clk),
    .running(running), .underrun(underrun), .underrun_flag(underrun_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard state, owned by the monitor process.
  logic [9:0] sbq[$];
  int         cyc = 0;
  int         n_out = 0;
  int         exp_period = 4;
  int         last_strobe = 0;
  int         entry_cyc = 0;
  int         hi_cnt = 0;
  bit         bp_mode = 0;
  bit         bp_chk_next = 0;
  bit         primed = 0;
  bit         have_prev = 0;
  bit         prev_clk = 0;
  bit         prev_running = 0;
  bit         mon_pv = 0;
  bit         strobe_s;
  logic [9:0] mon_pd = '0;
  logic [9:0] mon_exp;
  logic [9:0] last_out = 10'd512;

  always @(posedge clk) cyc = cyc + 1;

  always begin
    @(negedge clk);
    #2;
    mon_pv = s_valid && s_ready;
    mon_pd = s_data;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      sbq.delete();
      n_out = 0; primed = 0; have_prev = 0; hi_cnt = 0; bp_chk_next = 0;
      prev_clk = 0; prev_running = 0; last_out = 10'd512;
    end else begin
      strobe_s = prev_clk && !dac_clk && running;
      if (running && dac_clk) hi_cnt++;
      if (bp_chk_next) begin
        chk_eq("bp_ready_drop", s_ready, 1'b0);
        bp_chk_next = 0;
      end
      if (strobe_s) begin
        if (sbq.size() == 0) begin
          chk_eq("underrun_pulse", underrun, 1'b1);
          chk_eq("underrun_hold", dac_data, last_out);
        end else begin
          mon_exp = sbq.pop_front();
          chk_eq("underrun_quiet", underrun, 1'b0);
          chk_eq("dac_data", dac_data, mon_exp);
          last_out = mon_exp;
          n_out++;
          if (bp_mode) begin
            chk_eq("bp_ready_rise", s_ready, 1'b1);
            bp_chk_next = 1;
          end
        end
        if (have_prev) begin
          chk_eq("period", cyc - last_strobe, exp_period);
          chk_eq("dac_clk_high", hi_cnt, exp_period / 2);
        end else begin
          chk_eq("first_latency", cyc - entry_cyc, exp_period);
        end
        have_prev = 1;
        last_strobe = cyc;
        hi_cnt = 0;
      end else begin
        chk_eq("underrun_idle", underrun, 1'b0);
      end
      if (mon_pv) begin
        sbq.push_back(mon_pd);
        if (!primed && sbq.size() == 4) begin
          primed = 1;
          entry_cyc = cyc;
        end
      end
      if (prev_running && !running) begin
        sbq.delete();
        primed = 0; have_prev = 0; hi_cnt = 0;
      end
      prev_clk = dac_clk;
      prev_running = running;
    end
  end

  task automatic chk_reset_vals();
    chk_eq("rst_s_ready", s_ready, 1'b0);
    chk_eq("rst_dac_data", dac_data, 10'd512);
    chk_eq("rst_dac_clk", dac_clk, 1'b0);
    chk_eq("rst_running", running, 1'b0);
    chk_eq("rst_underrun", underrun, 1'b0);
    chk_eq("rst_flag", underrun_flag, 1'b0);
  endtask

  // Reset asserted mid-cycle; outputs must change without waiting for a clock.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    pll_lock = 1'b0; s_valid = 1'b0; clr_underrun = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic bring_up(input int d);
    div = 16'(d);
    exp_period = ((d == 0) ? 1 : d) + 1;
    pll_lock = 1'b1;
    for (int i = 0; i < 40 && !running; i++) @(negedge clk);
    chk_eq("bring_up", running, 1'b1);
  endtask

  task automatic push_sample(input logic [9:0] d);
    bit ok;
    ok = 0;
    s_valid = 1'b1;
    s_data = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (s_ready) begin
        @(posedge clk);
        ok = 1;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk_eq("push_accept", ok, 1'b1);
  endtask

  task automatic wait_outputs(input string tag, input int n, input int bound);
    for (int i = 0; i < bound && n_out < n; i++) @(negedge clk);
    chk_eq(tag, n_out, n);
  endtask

  initial begin
    rst_n = 1'b0; pll_lock = 1'b0; div = 16'd3; s_data = '0;
    s_valid = 1'b0; clr_underrun = 1'b0;

    // Lock bring-up: first edge sampling lock is edge 0, running at edge 10.
    apply_reset();
    pll_lock = 1'b1;
    repeat (10) @(negedge clk);
    chk_eq("lock_e9_running", running, 1'b0);
    @(negedge clk);
    chk_eq("lock_e10_running", running, 1'b1);
    chk_eq("lock_e10_ready", s_ready, 1'b1);

    // Second run with a one-cycle glitch sampled at edge 20.
    apply_reset();
    pll_lock = 1'b1;
    repeat (20) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    chk_eq("glitch_e20_running", running, 1'b1);
    @(negedge clk);
    chk_eq("glitch_e21_running", running, 1'b1);
    @(negedge clk);
    chk_eq("glitch_e22_running", running, 1'b0);
    chk_eq("glitch_e22_ready", s_ready, 1'b0);
    repeat (8) @(negedge clk);
    chk_eq("glitch_e30_running", running, 1'b0);
    @(negedge clk);
    chk_eq("glitch_e31_running", running, 1'b1);

    // Stream with div=3: four pushes prime, output every 4 cycles.
    apply_reset();
    bring_up(3);
    for (int k = 1; k <= 4; k++) push_sample(10'(k));
    chk_eq("prime_full_ready", s_ready, 1'b0);
    repeat (3) @(negedge clk);
    chk_eq("stream_before_first", dac_data, 10'd512);
    @(negedge clk);
    chk_eq("stream_first", dac_data, 10'd1);
    chk_eq("stream_ready_after_pop", s_ready, 1'b1);
    push_sample(10'd5);
    push_sample(10'd6);
    wait_outputs("stream_count", 6, 80);

    // Underrun with div=1.
    apply_reset();
    bring_up(1);
    for (int k = 1; k <= 5; k++) push_sample(10'(k));
    for (int i = 0; i < 40 && !underrun; i++) @(negedge clk);
    chk_eq("underrun_seen", underrun, 1'b1);
    chk_eq("underrun_data_hold", dac_data, 10'd5);
    chk_eq("underrun_flag_set", underrun_flag, 1'b1);
    chk_eq("underrun_out_count", n_out, 5);
    @(negedge clk);
    chk_eq("underrun_one_cycle", underrun, 1'b0);
    chk_eq("flag_sticky", underrun_flag, 1'b1);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    chk_eq("underrun_again", underrun, 1'b1);
    chk_eq("flag_set_wins", underrun_flag, 1'b1);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    chk_eq("flag_cleared", underrun_flag, 1'b0);
    @(negedge clk);
    chk_eq("flag_reset_again", underrun_flag, 1'b1);

    // Lock loss with data still buffered, then relock with fresh data.
    for (int k = 0; k < 4; k++) push_sample(10'h021 + 10'(k));
    pll_lock = 1'b0;
    @(negedge clk);
    chk_eq("loss_l0_running", running, 1'b1);
    @(negedge clk);
    chk_eq("loss_l1_running", running, 1'b1);
    @(negedge clk);
    chk_eq("loss_running", running, 1'b0);
    chk_eq("loss_dac_data", dac_data, 10'd512);
    chk_eq("loss_dac_clk", dac_clk, 1'b0);
    chk_eq("loss_ready", s_ready, 1'b0);
    chk_eq("loss_flag_kept", underrun_flag, 1'b1);
    bring_up(1);
    for (int k = 1; k <= 4; k++) push_sample(10'h100 + 10'(k));
    @(negedge clk);
    chk_eq("relock_before_first", dac_data, 10'd512);
    @(negedge clk);
    chk_eq("relock_first", dac_data, 10'h101);
    push_sample(10'h105);
    repeat (6) @(negedge clk);

    // Backpressure with div=15 and a continuously valid source.
    apply_reset();
    bring_up(15);
    bp_mode = 1;
    for (int k = 1; k <= 100; k++) push_sample(10'(k));
    bp_mode = 0;
    wait_outputs("bp_count", 100, 400);
    chk_eq("bp_flag_clear_before_drain", underrun_flag, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
